// File: rtl/peak_result_streamer.sv
// peak_result_streamer: ping-pong capture of a parallel per-pixel peak frame, streamed out one pixel per valid/ready beat
// Ports:
//   clk, res            rising-edge clock, asynchronous active-high reset
//   peak_load/peak_flat one-cycle strobe qualifying a full frame, pixel p at [p*NP +: NP]
//   out_valid/out_ready beat handshake; out_data/out_pix/out_last/out_frame describe the beat
//   frame_drop          one-cycle pulse when a load finds no free bank
//   drop_count          saturating count of dropped frames
//   busy                at least one bank holds an unreleased frame
module peak_result_streamer #(
    parameter int NP        = 16,
    parameter int PIXEL_NUM = 200,
    parameter int PIX_W     = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    peak_load,
    input  logic [NP*PIXEL_NUM-1:0] peak_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NP-1:0]           out_data,
    output logic [PIX_W-1:0]        out_pix,
    output logic                    out_last,
    output logic [7:0]              out_frame,
    output logic                    frame_drop,
    output logic [7:0]              drop_count,
    output logic                    busy
);
    typedef enum logic {IDLE, STREAM} state_t;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);
    logic [NP-1:0]    r_mem [2][PIXEL_NUM];
    logic [1:0]       r_full;
    logic [7:0]       r_tag [2];
    logic             r_wp;
    logic             r_rp;
    logic [7:0]       r_fcnt;
    state_t           r_state;
    logic             w_release;
    logic             w_cap;
    logic [PIX_W-1:0] w_nxt;
    assign w_release = (r_state == STREAM) && out_valid && out_ready && out_last;
    // a bank being released this cycle counts as free for a same-cycle capture
    assign w_cap     = peak_load && (!r_full[r_wp] || (w_release && r_wp == r_rp));
    assign w_nxt     = out_pix + 1'b1;
    assign busy      = |r_full;
    always_ff @(posedge clk) begin
        if (w_cap)
            for (int p = 0; p < PIXEL_NUM; p++)
                r_mem[r_wp][p] <= peak_flat[p*NP +: NP];
    end
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_full     <= '0;
            r_tag[0]   <= '0;
            r_tag[1]   <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_fcnt     <= '0;
            r_state    <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pix    <= '0;
            out_last   <= 1'b0;
            out_frame  <= '0;
            frame_drop <= 1'b0;
            drop_count <= '0;
        end else begin
            // clear before set so a same-bank release+capture leaves the bank FULL
            if (w_release)
                r_full[r_rp] <= 1'b0;
            if (w_cap) begin
                r_full[r_wp] <= 1'b1;
                r_tag[r_wp]  <= r_fcnt;
                r_fcnt       <= r_fcnt + 1'b1;
                r_wp         <= ~r_wp;
            end
            frame_drop <= peak_load && !w_cap;
            if (peak_load && !w_cap && drop_count != 8'hFF)
                drop_count <= drop_count + 1'b1;
            if (r_state == IDLE) begin
                if (r_full[r_rp]) begin
                    r_state   <= STREAM;
                    out_valid <= 1'b1;
                    out_pix   <= '0;
                    out_data  <= r_mem[r_rp][0];
                    out_frame <= r_tag[r_rp];
                    out_last  <= (LAST_PIX == '0);
                end
            end else if (out_ready) begin
                if (out_last) begin
                    r_rp <= ~r_rp;
                    if (r_full[~r_rp]) begin
                        out_pix   <= '0;
                        out_data  <= r_mem[~r_rp][0];
                        out_frame <= r_tag[~r_rp];
                        out_last  <= (LAST_PIX == '0);
                    end else begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end else begin
                    out_pix  <= w_nxt;
                    out_data <= r_mem[r_rp][w_nxt];
                    out_last <= (w_nxt == LAST_PIX);
                end
            end
        end
    end
endmodule

// File: tb/tb_peak_result_streamer.sv
// tb_peak_result_streamer: randomized scoreboard bench for peak_result_streamer
module tb_peak_result_streamer;
    localparam int NP = 16;
    localparam int PN = 200;
    localparam int PW = 8;
    logic clk = 1'b0;
    logic res = 1'b1;
    logic peak_load = 1'b0;
    logic out_ready = 1'b0;
    logic [NP*PN-1:0] peak_flat = '0;
    logic out_valid, out_last, frame_drop, busy;
    logic [NP-1:0] out_data;
    logic [PW-1:0] out_pix;
    logic [7:0] out_frame, drop_count;

    peak_result_streamer #(.NP(NP), .PIXEL_NUM(PN), .PIX_W(PW)) dut (
        .clk(clk), .res(res), .peak_load(peak_load), .peak_flat(peak_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pix(out_pix), .out_last(out_last), .out_frame(out_frame),
        .frame_drop(frame_drop), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  p;
        logic        l;
        logic [7:0]  f;
    } beat_t;

    beat_t q[$];
    beat_t nb, cur, held, exp_b;
    int n_chk = 0, n_fail = 0;
    int accepted = 0, done_cnt = 0, fcnt = 0, exp_dc = 0, beats = 0;
    bit exp_fd = 0, hold = 0, need_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s actual=timeout required=completion at %0t", name, $time);
    endtask

    // reference model: at most two frames outstanding; a frame is outstanding from its
    // accepted load until its last beat is consumed (that same edge frees room)
    always @(posedge clk) begin
        if (!res && peak_load) begin
            if (accepted - done_cnt < 2) begin
                for (int p = 0; p < PN; p++) begin
                    nb.d = peak_flat[p*NP +: NP];
                    nb.p = 8'(p);
                    nb.l = (p == PN - 1);
                    nb.f = 8'(fcnt);
                    q.push_back(nb);
                end
                accepted++;
                fcnt = (fcnt + 1) % 256;
                exp_fd = 0;
            end else begin
                exp_fd = 1;
                if (exp_dc < 255) exp_dc++;
            end
        end else begin
            exp_fd = 0;
        end
    end

    always @(negedge clk) begin
        if (res) begin
            hold = 0;
            need_valid = 0;
        end else begin
            cur = {out_data, out_pix, out_last, out_frame};
            chk("frame_drop", frame_drop, exp_fd);
            chk("drop_count", drop_count, 64'(exp_dc));
            chk("busy", busy, accepted != done_cnt);
            if (need_valid) chk("no_bubble", out_valid, 1);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_beat", cur, held);
            end
            if (q.size() == 0) chk("idle_valid", out_valid, 0);
            hold = out_valid && !out_ready;
            held = cur;
            need_valid = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    timeout("extra_beat");
                end else begin
                    exp_b = q.pop_front();
                    chk("beat", cur, exp_b);
                    beats++;
                    if (exp_b.l) done_cnt++;
                    need_valid = q.size() > 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit rnd);
        for (int p = 0; p < PN; p++)
            peak_flat[p*NP +: NP] = rnd ? 16'($urandom) : 16'(p * 3);
        peak_load = 1'b1;
        tick();
        peak_load = 1'b0;
    endtask

    task automatic drain(input int lim, input bit rnd_ready);
        int c = 0;
        while ((q.size() != 0 || out_valid) && c < lim) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        out_ready = 1'b1;
        if (c >= lim) timeout("drain");
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, dc0, c;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pix", out_pix, 0);
        chk("rst_last", out_last, 0);
        chk("rst_frame", out_frame, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_dcount", drop_count, 0);
        chk("rst_busy", busy, 0);
        res = 1'b0;
        tick();

        out_ready = 1'b1;
        load_frame(0);
        chk("latency_t", out_valid, 0);
        tick();
        chk("latency_t1", out_valid, 1);
        b0 = beats;
        drain(1000, 0);
        chk("t1_beats", beats - b0, PN);

        b0 = beats;
        load_frame(0);
        drain(3000, 1);
        chk("t2_beats", beats - b0, PN);

        out_ready = 1'b0;
        b0 = beats;
        load_frame(1);
        load_frame(1);
        load_frame(1);
        tick();
        chk("t3_drop_count", drop_count, 1);
        repeat (5) tick();
        out_ready = 1'b1;
        drain(2000, 0);
        chk("t3_beats", beats - b0, 2 * PN);

        b0 = beats;
        dc0 = exp_dc;
        load_frame(1);
        load_frame(1);
        c = 0;
        while (!(out_valid && out_ready && out_last) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) timeout("t4_last_wait");
        for (int p = 0; p < PN; p++) peak_flat[p*NP +: NP] = 16'($urandom);
        peak_load = 1'b1;
        @(posedge clk);
        #1 peak_load = 1'b0;
        drain(2000, 0);
        chk("t4_beats", beats - b0, 3 * PN);
        chk("t4_no_drop", drop_count, 64'(dc0));

        out_ready = 1'b0;
        load_frame(1);
        load_frame(1);
        for (int i = 0; i < 260; i++) load_frame(1);
        tick();
        chk("t5_saturate", drop_count, 255);
        out_ready = 1'b1;
        drain(2000, 0);
        for (int i = 0; i < 256; i++) begin
            load_frame(1);
            repeat (PN - 1) tick();
        end
        drain(2000, 0);

        load_frame(0);
        c = 0;
        while (!(out_valid && out_pix == 8'd57) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) timeout("t6_beat57_wait");
        #2 res = 1'b1;
        #1;
        chk("ares_valid", out_valid, 0);
        chk("ares_data", out_data, 0);
        chk("ares_pix", out_pix, 0);
        chk("ares_last", out_last, 0);
        chk("ares_frame", out_frame, 0);
        chk("ares_drop", frame_drop, 0);
        chk("ares_dcount", drop_count, 0);
        chk("ares_busy", busy, 0);
        q.delete();
        accepted = 0;
        done_cnt = 0;
        fcnt = 0;
        exp_dc = 0;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        tick();
        b0 = beats;
        load_frame(1);
        tick();
        chk("t6_first_pix", out_pix, 0);
        chk("t6_first_tag", out_frame, 0);
        drain(1000, 0);
        chk("t6_beats", beats - b0, PN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
